// File: rtl/sys_controller.sv
// Sequencer for a weight-stationary systolic array. It preloads tile weights,
// swaps them into the array, streams input features and drains the array at the end of a job.
module sys_controller #(
  parameter int TILE_W       = 8,
  parameter int SYS_ROWS     = 8,
  parameter int SYS_COLS     = 8,
  parameter int DRAIN_CYCLES = SYS_ROWS + SYS_COLS - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              w_done,
  input  logic              if_done,
  output logic              w_buffer_read,
  output logic              if_buffer_read,
  output logic              clr_w,
  output logic              clr_if,
  output logic              switch,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    W_PRELOAD,
    SWITCH,
    STREAM,
    WAIT_W,
    DRAIN,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [TILE_W-1:0] tiles, tiles_n;
  logic [TILE_W-1:0] tile_n;
  logic              w_ready, w_ready_n;
  logic              first_sw, first_sw_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              zero_job;
  logic              last_tile;
  logic              preload_n;

  assign last_tile = (tile_idx == tiles - 1'b1);

  always_comb begin
    state_n    = state;
    tiles_n    = tiles;
    tile_n     = tile_idx;
    w_ready_n  = w_ready;
    first_sw_n = first_sw;
    cnt_n      = cnt;
    zero_job   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_tiles != '0) begin
            tiles_n    = num_tiles;
            tile_n     = '0;
            first_sw_n = 1'b1;
            w_ready_n  = 1'b0;
            state_n    = W_PRELOAD;
          end else begin
            zero_job = 1'b1;
          end
        end
      end
      W_PRELOAD: begin
        if (w_done) state_n = SWITCH;
      end
      SWITCH: begin
        // The first swap of a job brings in tile 0, which tile_idx already holds
        w_ready_n  = 1'b0;
        first_sw_n = 1'b0;
        if (!first_sw) tile_n = tile_idx + 1'b1;
        state_n    = STREAM;
      end
      STREAM: begin
        if (w_done) w_ready_n = 1'b1;
        if (if_done) begin
          if (last_tile) begin
            cnt_n   = CNT_W'(DRAIN_CYCLES - 1);
            state_n = DRAIN;
          end else if (w_ready || w_done) begin
            state_n = SWITCH;
          end else begin
            state_n = WAIT_W;
          end
        end
      end
      WAIT_W: begin
        if (w_done) state_n = SWITCH;
      end
      DRAIN: begin
        if (cnt == '0) state_n = DONE;
        else           cnt_n   = cnt - 1'b1;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Next tile's weights load while the current tile streams, until they are ready
  assign preload_n = (tile_n < tiles_n - 1'b1) && !w_ready_n;

  // Outputs are registered from the next-state values so they line up with the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      tiles          <= '0;
      tile_idx       <= '0;
      w_ready        <= 1'b0;
      first_sw       <= 1'b0;
      cnt            <= '0;
      w_buffer_read  <= 1'b0;
      if_buffer_read <= 1'b0;
      clr_w          <= 1'b1;
      clr_if         <= 1'b1;
      switch         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      tiles          <= tiles_n;
      tile_idx       <= tile_n;
      w_ready        <= w_ready_n;
      first_sw       <= first_sw_n;
      cnt            <= cnt_n;
      w_buffer_read  <= (state_n == W_PRELOAD) || (state_n == WAIT_W) ||
                        ((state_n == STREAM) && preload_n);
      clr_w          <= !((state_n == W_PRELOAD) || (state_n == WAIT_W) ||
                          ((state_n == STREAM) && preload_n));
      if_buffer_read <= (state_n == STREAM);
      clr_if         <= (state_n != STREAM);
      switch         <= (state_n == SWITCH);
      busy           <= (state_n != IDLE);
      done           <= (state_n == DONE) || zero_job;
    end
  end

endmodule

// File: doc/sys_controller.md
SYS_CONTROLLER -- requirements
Module: sys_controller

Interface
REQ-001 SHALL have parameter TILE_W, default 8, meaning the width of the tile-count input and the tile-index output.
REQ-002 SHALL have parameter DRAIN_CYCLES, default sys_rows+sys_cols-1 (from Config), meaning the cycles spent flushing the array after the last input row.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a job; sampled only in IDLE.
REQ-006 SHALL have port num_tiles, input, TILE_W bits: the number of weight tiles in the job; sampled with start.
REQ-007 SHALL have port w_done, input, 1 bit: datapath status, weight load of the current tile complete.
REQ-008 SHALL have port if_done, input, 1 bit: datapath status, input-feature stream of the current tile complete.
REQ-009 SHALL have ports w_buffer_read and if_buffer_read, outputs, 1 bit each: read enables to the weight and input buffers.
REQ-010 SHALL have ports clr_w and clr_if, outputs, 1 bit each: clears for the datapath weight and input counters.
REQ-011 SHALL have port switch, output, 1 bit: swaps the preloaded weights into the active array.
REQ-012 SHALL have ports busy (1 bit), done (1 bit) and tile_idx (TILE_W bits), all outputs: busy = not IDLE; done = end-of-job pulse; tile_idx = index of the tile currently streaming.

Function
REQ-013 SHALL implement the states IDLE, W_PRELOAD, SWITCH, STREAM, WAIT_W, DRAIN and DONE.
REQ-014 In IDLE, all outputs SHALL be 0 except clr_w=1 and clr_if=1.
REQ-015 In IDLE, start=1 with num_tiles!=0 SHALL latch num_tiles, clear tile_idx to 0 and move to W_PRELOAD.
REQ-016 In IDLE, start=1 with num_tiles==0 SHALL pulse done for the next cycle only, while the block stays IDLE.
REQ-017 In W_PRELOAD, the block SHALL drive w_buffer_read=1, clr_w=0 and clr_if=1; on w_done=1 it SHALL move to SWITCH.
REQ-018 SWITCH SHALL last exactly one cycle, driving switch=1, clr_w=1 and clr_if=1 with both reads at 0, then move to STREAM.
REQ-019 On entering STREAM from a second or later SWITCH, tile_idx SHALL increment by 1.
REQ-020 In STREAM, the block SHALL drive if_buffer_read=1 and clr_if=0.
REQ-021 In STREAM, while tile_idx < latched-1 and the internal flag w_ready=0, the block SHALL also drive w_buffer_read=1 and clr_w=0, so the next tile's weights preload during the stream.
REQ-022 In STREAM, w_done=1 SHALL set w_ready; while w_ready=1, w_buffer_read=0 and clr_w=1 so the weight counter freezes.
REQ-023 On if_done=1 in STREAM on the last tile, the block SHALL move to DRAIN.
REQ-024 On if_done=1 in STREAM on a non-last tile, it SHALL move to SWITCH if w_ready=1 or w_done=1 in the same cycle, otherwise to WAIT_W.
REQ-025 In WAIT_W, the block SHALL drive w_buffer_read=1, clr_w=0 and clr_if=1; on w_done=1 it SHALL move to SWITCH.
REQ-026 SWITCH SHALL clear w_ready.
REQ-027 In DRAIN, both reads SHALL be 0 and both clears 1; after exactly DRAIN_CYCLES cycles (internal down-counter) the block SHALL move to DONE.
REQ-028 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE; tile_idx SHALL hold its value until the next start.
REQ-029 start SHALL be ignored in every state other than IDLE.
REQ-030 w_done or if_done asserted in a state that does not sample them SHALL be ignored.
REQ-031 switch and if_buffer_read SHALL never be 1 in the same cycle.
REQ-032 All outputs SHALL be registered or decoded from state only; no input SHALL reach an output combinationally.

Reset
REQ-033 When rst=0 at a clock edge, the block SHALL go to IDLE and clear tile_idx, w_ready, the drain counter and the latched tile count; done=0, busy=0, both reads 0, clr_w=1, clr_if=1 and switch=0 from the next cycle.
REQ-034 Reset SHALL take priority over start and all status inputs, including when asserted mid-job in any state.

Verification
REQ-035 Single tile: num_tiles=1, start, with w_done 5 cycles later and if_done 8 cycles after STREAM entry -> one switch pulse, no w_buffer_read during STREAM, DRAIN for DRAIN_CYCLES, done pulses once and tile_idx=0.
REQ-036 Three tiles, w_done arriving before if_done each tile -> SWITCH directly after STREAM each time, no WAIT_W, exactly 3 switch pulses, tile_idx sequence 0,1,2.
REQ-037 Two tiles, if_done 3 cycles before w_done -> WAIT_W for 3 cycles with w_buffer_read=1, then SWITCH, tile_idx=1.
REQ-038 w_done and if_done in the same STREAM cycle on tile 0 of 2 -> next cycle is SWITCH, not WAIT_W.
REQ-039 start with num_tiles=0 -> done=1 for one cycle and busy stays 0; start pulsed during STREAM -> no effect.
REQ-040 rst=0 during STREAM on tile 1 -> next cycle IDLE, all outputs at reset values; a new start then runs normally from tile 0.
